beat_sequencer: RTL and testbench



---
 rtl/beat_sequencer_pkg.sv | 16 +
 rtl/beat_sequencer_edge_detect.sv | 18 +
 rtl/beat_sequencer.sv | 150 +++++++++++++++
 tb/tb_beat_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_sequencer_pkg.sv
// Shared sequencer definitions: FSM state encoding and default note codes.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_WAIT_BEAT = 3'd4
  } seq_state_t;

  // The tone generator mutes on REST_CODE; the sequencer forwards it like any note.
  localparam logic [7:0] REST_CODE_DEF = 8'h00;
  localparam logic [7:0] END_CODE_DEF  = 8'hFF;

endpackage

// File: rtl/beat_sequencer_edge_detect.sv
// Rising-edge detector for the prescaler beat level; tick is one cycle per beat.
module beat_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_i,
  output logic tick_o
);

  logic beat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) beat_q <= 1'b0;
    else       beat_q <= beat_i;
  end

  assign tick_o = beat_i & ~beat_q;

endmodule

// File: rtl/beat_sequencer.sv
// Steps through note memory one entry per beat and hands each note to the tone
// generator over valid/ready; handles stop, looping, end marker and lost beats.
//
// state        | meaning
// IDLE         | stopped, waiting for play
// FETCH        | mem_addr driven, memory read in flight
// WAIT_DATA    | mem_data valid, decode note / end of song
// PRESENT      | note_out offered, waiting for note_ready
// WAIT_BEAT    | note accepted, waiting for next beat tick
module beat_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NOTE_W = 8,
  parameter logic [NOTE_W-1:0] END_CODE = NOTE_W'(END_CODE_DEF)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              beat_in,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NOTE_W-1:0] mem_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  input  logic              note_ready,
  output logic              playing,
  output logic              done,
  output logic              beat_overrun
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              pending_q, pending_d;
  logic              tick;
  logic              song_end;

  beat_edge_detect u_edge (
    .clk_i  (CLK),
    .rst_i  (RST),
    .beat_i (beat_in),
    .tick_o (tick)
  );

  // Last address is treated as an implicit end marker so the counter never wraps.
  assign song_end = (mem_data == END_CODE) || (addr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    note_d    = note_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    pending_d = pending_q;

    if (tick && pending_q && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (play) begin
          addr_d    = '0;
          overrun_d = 1'b0;
          pending_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (tick) pending_d = 1'b1;
        state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (tick) pending_d = 1'b1;
        if (song_end) begin
          if (loop_en) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            done_d    = 1'b1;
            pending_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else begin
          note_d  = mem_data;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (tick) pending_d = 1'b1;
        if (valid_q && note_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT_BEAT;
        end
      end
      ST_WAIT_BEAT: begin
        if (tick || pending_q) begin
          addr_d    = addr_q + ADDR_W'(1);
          pending_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // stop overrides everything, including a simultaneous play.
    if (stop) begin
      state_d   = ST_IDLE;
      addr_d    = addr_q;
      note_d    = note_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      pending_d = 1'b0;
      overrun_d = overrun_q | (tick & pending_q & (state_q != ST_IDLE));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      note_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
    end
  end

  assign mem_addr     = addr_q;
  assign note_out     = note_q;
  assign note_valid   = valid_q;
  assign done         = done_q;
  assign beat_overrun = overrun_q;
  assign playing      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: registered note ROM, scripted beats, and a scoreboard
// of expected notes checked at each accepted handshake.
module tb_beat_sequencer;
  import seq_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       beat_in = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] note_out;
  logic       note_valid;
  logic       note_ready = 1'b1;
  logic       playing;
  logic       done;
  logic       beat_overrun;

  logic [7:0] rom [256];
  logic [7:0] sb_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         done_snap;

  beat_sequencer dut (
    .CLK          (CLK),
    .RST          (RST),
    .beat_in      (beat_in),
    .play         (play),
    .stop         (stop),
    .loop_en      (loop_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .note_out     (note_out),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .playing      (playing),
    .done         (done),
    .beat_overrun (beat_overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) mem_data <= rom[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load_song(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    for (int i = 0; i < 256; i++) rom[i] = 8'h11;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  // Start from IDLE: play in cycle 0, first note expected valid in cycle 3.
  task automatic start_song(input logic [7:0] first);
    play = 1'b1;
    sb_q.push_back(first);
    step(1);
    play = 1'b0;
    check_eq("start_addr", 32'(mem_addr), 32'd0);
    check_eq("start_playing", 32'(playing), 32'd1);
    step(2);
    check_eq("first_valid", 32'(note_valid), 32'd1);
    check_eq("first_note", 32'(note_out), 32'(first));
  endtask

  task automatic stop_song();
    beat_in = 1'b0;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check_eq("stop_playing", 32'(playing), 32'd0);
    step(2);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (done) done_cnt++;
      if (note_valid && note_ready) begin
        if (sb_q.size() == 0) check_eq("sb_extra_note", 32'(note_out), 32'hDEAD);
        else check_eq("sb_note", 32'(note_out), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 1000000", $time);
    $fatal(1);
  end

  initial begin
    load_song(8'h3C, 8'h40, END_CODE_DEF, 8'h11);
    step(3);
    RST = 1'b0;
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_note", 32'(note_out), 32'd0);
    check_eq("rst_valid", 32'(note_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_overrun", 32'(beat_overrun), 32'd0);
    check_eq("rst_playing", 32'(playing), 32'd0);
    step(2);

    // Plain song, no loop: done after second tick.
    start_song(8'h3C);
    step(1);
    beat_in = 1'b1; sb_q.push_back(8'h40);
    step(3);
    check_eq("t1_valid", 32'(note_valid), 32'd1);
    check_eq("t1_note", 32'(note_out), 32'h40);
    beat_in = 1'b0;
    step(2);
    beat_in = 1'b1;
    step(3);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_idle", 32'(playing), 32'd0);
    step(1);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    beat_in = 1'b0;
    step(2);

    // Looping: end marker jumps back to address 0, no done.
    loop_en = 1'b1;
    done_snap = done_cnt;
    start_song(8'h3C);
    step(1);
    beat_in = 1'b1; sb_q.push_back(8'h40);
    step(3);
    check_eq("t2_note40", 32'(note_out), 32'h40);
    beat_in = 1'b0;
    step(2);
    beat_in = 1'b1; sb_q.push_back(8'h3C);
    step(5);
    check_eq("t2_loop_valid", 32'(note_valid), 32'd1);
    check_eq("t2_loop_note", 32'(note_out), 32'h3C);
    check_eq("t2_loop_addr", 32'(mem_addr), 32'd0);
    step(1);
    check_eq("t2_no_done", 32'(done_cnt), 32'(done_snap));
    stop_song();
    loop_en = 1'b0;

    // Back-pressure across three beats: pending then overrun, one advance.
    note_ready = 1'b0;
    start_song(8'h3C);
    step(1);
    for (int b = 0; b < 3; b++) begin
      beat_in = 1'b1;
      step(3);
      beat_in = 1'b0;
      step(3);
      check_eq("t3_hold_note", 32'(note_out), 32'h3C);
      check_eq("t3_hold_valid", 32'(note_valid), 32'd1);
      check_eq("t3_overrun", 32'(beat_overrun), (b == 0) ? 32'd0 : 32'd1);
    end
    note_ready = 1'b1; sb_q.push_back(8'h40);
    step(4);
    check_eq("t3_adv_valid", 32'(note_valid), 32'd1);
    check_eq("t3_adv_note", 32'(note_out), 32'h40);
    step(10);
    check_eq("t3_one_adv", 32'(mem_addr), 32'd1);
    check_eq("t3_still_play", 32'(playing), 32'd1);
    stop_song();

    // stop with play while presenting the second note.
    play = 1'b1;
    sb_q.push_back(8'h3C);
    step(1);
    play = 1'b0;
    check_eq("t4_overrun_clr", 32'(beat_overrun), 32'd0);
    step(3);
    note_ready = 1'b0;
    beat_in = 1'b1;
    step(3);
    check_eq("t4_present", 32'(note_valid), 32'd1);
    stop = 1'b1; play = 1'b1;
    step(1);
    stop = 1'b0; play = 1'b0; beat_in = 1'b0;
    check_eq("t4_valid", 32'(note_valid), 32'd0);
    check_eq("t4_playing", 32'(playing), 32'd0);
    check_eq("t4_addr", 32'(mem_addr), 32'd1);
    check_eq("t4_note_hold", 32'(note_out), 32'h40);
    note_ready = 1'b1;
    step(2);

    // Rest code is forwarded like any note.
    load_song(8'h3C, REST_CODE_DEF, 8'h48, END_CODE_DEF);
    done_snap = done_cnt;
    start_song(8'h3C);
    step(1);
    beat_in = 1'b1; sb_q.push_back(REST_CODE_DEF);
    step(3);
    check_eq("t5_rest_valid", 32'(note_valid), 32'd1);
    check_eq("t5_rest_note", 32'(note_out), 32'(REST_CODE_DEF));
    beat_in = 1'b0;
    step(2);
    beat_in = 1'b1; sb_q.push_back(8'h48);
    step(3);
    check_eq("t5_note48", 32'(note_out), 32'h48);
    beat_in = 1'b0;
    step(2);
    beat_in = 1'b1;
    step(3);
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_end_addr", 32'(mem_addr), 32'd3);
    beat_in = 1'b0;
    step(2);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'(done_snap + 1));

    // Reset while a fetch is in flight.
    load_song(8'h3C, 8'h40, END_CODE_DEF, 8'h11);
    start_song(8'h3C);
    step(1);
    beat_in = 1'b1;
    step(2);
    RST = 1'b1; beat_in = 1'b0;
    step(1);
    RST = 1'b0;
    check_eq("t6_addr", 32'(mem_addr), 32'd0);
    check_eq("t6_note", 32'(note_out), 32'd0);
    check_eq("t6_valid", 32'(note_valid), 32'd0);
    check_eq("t6_playing", 32'(playing), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_overrun", 32'(beat_overrun), 32'd0);
    step(2);
    start_song(8'h3C);
    step(2);
    stop_song();

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
